// File: rtl/bk_add_arbiter.sv
// bk_add_arbiter: round-robin share of one external W-bit adder among NREQ requesters,
// with a two-stage operand/result pipeline and carry chaining for multi-word adds.
module bk_add_arbiter #(
   parameter int N = 5,
   parameter int NREQ = 4,
   localparam int W = 2 ** N,
   localparam int IW = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ-1:0]    req_last,
   input  logic [NREQ-1:0]    req_cin,
   input  logic [NREQ*W-1:0]  req_a,
   input  logic [NREQ*W-1:0]  req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IW-1:0]      rsp_id,
   output logic [W-1:0]       rsp_sum,
   output logic               rsp_cout,
   output logic               rsp_last,
   output logic [W-1:0]       add_a,
   output logic [W-1:0]       add_b,
   output logic               add_cin,
   input  logic [W-1:0]       add_sum,
   input  logic               add_cout,
   output logic               busy
);
   logic          s1_v, s1_cin, s1_last, s2_v, s2_cout, s2_last;
   logic [W-1:0]  s1_a, s1_b, s2_sum;
   logic [IW-1:0] s1_id, s2_id, lock_id, rr_ptr;
   logic          lock, carry_reg;
   logic          s2_adv, s1_adv, gnt_ok, win_v, acc, cin_sel;
   logic [IW-1:0] win, idx;
   logic [W-1:0]  a_arr [NREQ];
   logic [W-1:0]  b_arr [NREQ];

   assign s2_adv = !s2_v | rsp_ready;
   assign s1_adv = s1_v & s2_adv;
   assign gnt_ok = !s1_v | s1_adv;

   // descending scan so the valid index closest above rr_ptr is the last one written
   always_comb begin
      win = lock ? lock_id : rr_ptr;
      win_v = lock & req_valid[lock_id];
      idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = rr_ptr + IW'(k);
         if (!lock && req_valid[idx]) begin
            win = idx;
            win_v = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = req_a[i*W +: W];
         b_arr[i] = req_b[i*W +: W];
      end
   end

   assign req_ready = (gnt_ok & win_v & !rst) ? NREQ'(1) << win : '0;
   assign acc = |req_ready;
   // a chained beat meeting its predecessor in s1 takes that beat's live carry-out
   assign cin_sel = !lock ? req_cin[win] :
                    (s1_v & s1_id == lock_id & !s1_last) ? add_cout : carry_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v <= 1'b0;
         s1_a <= '0;
         s1_b <= '0;
         s1_cin <= 1'b0;
         s1_id <= '0;
         s1_last <= 1'b0;
         s2_v <= 1'b0;
         s2_sum <= '0;
         s2_cout <= 1'b0;
         s2_id <= '0;
         s2_last <= 1'b0;
         lock <= 1'b0;
         lock_id <= '0;
         carry_reg <= 1'b0;
         rr_ptr <= '0;
      end else begin
         if (s2_adv) s2_v <= s1_v;
         if (s1_adv) begin
            s2_sum <= add_sum;
            s2_cout <= add_cout;
            s2_id <= s1_id;
            s2_last <= s1_last;
         end
         if (s1_adv && !s1_last) carry_reg <= add_cout;
         if (acc) begin
            s1_v <= 1'b1;
            s1_a <= a_arr[win];
            s1_b <= b_arr[win];
            s1_cin <= cin_sel;
            s1_id <= win;
            s1_last <= req_last[win];
            lock <= !req_last[win];
            lock_id <= win;
            if (req_last[win]) rr_ptr <= win + IW'(1);
         end else if (s1_adv) begin
            s1_v <= 1'b0;
         end
      end
   end

   assign add_a = s1_a;
   assign add_b = s1_b;
   assign add_cin = s1_cin;
   assign rsp_valid = s2_v;
   assign rsp_id = s2_id;
   assign rsp_sum = s2_sum;
   assign rsp_cout = s2_cout;
   assign rsp_last = s2_last;
   assign busy = s1_v | s2_v | lock;
endmodule

// File: tb/tb_bk_add_arbiter.sv
// tb_bk_add_arbiter: scoreboard bench for bk_add_arbiter; the bench supplies the shared adder.
module tb_bk_add_arbiter;
   localparam int N = 5;
   localparam int NREQ = 4;
   localparam int W = 32;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NREQ-1:0] req_valid = '0, req_last = '0, req_cin = '0, req_ready;
   logic [NREQ*W-1:0] req_a = '0, req_b = '0;
   logic rsp_valid, rsp_cout, rsp_last, add_cin, add_cout, busy;
   logic rsp_ready = 1'b1;
   logic [IW-1:0] rsp_id;
   logic [W-1:0] rsp_sum, add_a, add_b, add_sum;

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

   bk_add_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_last(req_last), .req_cin(req_cin), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_last(rsp_last),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
   );

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   logic [63:0] q[$];
   logic [NREQ-1:0] in_chain = '0, ccar = '0;
   logic [W:0] m_s;
   logic m_c;
   logic [63:0] held;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: expected {id,last,cout,sum} pushed at accept, compared at response
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         in_chain = '0;
      end else begin
         chk("ready_onehot", {63'b0, $onehot0(req_ready)}, 64'd1);
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               m_c = in_chain[i] ? ccar[i] : req_cin[i];
               m_s = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]} + {32'b0, m_c};
               ccar[i] = m_s[W];
               in_chain[i] = !req_last[i];
               q.push_back({28'b0, IW'(i), req_last[i], m_s});
               acc_cnt++;
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) chk("rsp_unexpected", 64'(q.size()), 64'd1);
            else chk("rsp", {28'b0, rsp_id, rsp_last, rsp_cout, rsp_sum}, q.pop_front());
         end
      end
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic last);
      req_valid[i] = v;
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_cin[i] = cin;
      req_last[i] = last;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      req_valid = '1;
      repeat (2) cyc;
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_add_a", 64'(add_a), 64'd0);
      cyc;
      rst = 1'b0;
      req_valid = '0;
      // single beat: latency and wraparound carry
      set_req(1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      chk("t1_ready", 64'(req_ready), 64'h2);
      cyc;
      req_valid = '0;
      @(negedge clk);
      chk("t1_lat1", 64'(rsp_valid), 64'd0);
      cyc;
      @(negedge clk);
      chk("t1_lat2", 64'(rsp_valid), 64'd1);
      chk("t1_sum", 64'(rsp_sum), 64'd0);
      chk("t1_cout", 64'(rsp_cout), 64'd1);
      chk("t1_id", 64'(rsp_id), 64'd1);
      cyc;
      // round robin from reset
      rst = 1'b1;
      cyc;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, $urandom, $urandom, 1'($urandom_range(1)), 1'b1);
         @(negedge clk);
         chk("t2_grant", 64'(req_ready), 64'(1 << (k % 4)));
         cyc;
      end
      req_valid = '0;
      repeat (3) cyc;
      // 96-bit chained add on req 2 while req 0 waits
      set_req(2, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t3_b0", 64'(req_ready), 64'h4);
      cyc;
      set_req(2, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
      set_req(0, 1'b1, 32'h7, 32'h8, 1'b0, 1'b1);
      @(negedge clk);
      chk("t3_b1", 64'(req_ready), 64'h4);
      chk("t3_busy", 64'(busy), 64'd1);
      cyc;
      set_req(2, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      chk("t3_b2", 64'(req_ready), 64'h4);
      cyc;
      req_valid[2] = 1'b0;
      @(negedge clk);
      chk("t3_r0", 64'(req_ready), 64'h1);
      cyc;
      req_valid = '0;
      repeat (3) cyc;
      // chain gap on req 3 with req 1 starved
      set_req(3, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t4_b0", 64'(req_ready), 64'h8);
      cyc;
      req_valid[3] = 1'b0;
      set_req(1, 1'b1, 32'h3, 32'h4, 1'b0, 1'b1);
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         chk("t4_gap", 64'(req_ready), 64'd0);
         chk("t4_busy", 64'(busy), 64'd1);
         cyc;
      end
      set_req(3, 1'b1, 32'h5, 32'h6, 1'b0, 1'b1);
      @(negedge clk);
      chk("t4_b1", 64'(req_ready), 64'h8);
      cyc;
      req_valid[3] = 1'b0;
      @(negedge clk);
      chk("t4_r1", 64'(req_ready), 64'h2);
      cyc;
      req_valid = '0;
      repeat (3) cyc;
      // backpressure with three requests pending
      rsp_ready = 1'b0;
      held = '0;
      acc_cnt = 0;
      set_req(0, 1'b1, 32'h10, 32'h20, 1'b0, 1'b1);
      set_req(1, 1'b1, 32'h30, 32'h40, 1'b1, 1'b1);
      set_req(2, 1'b1, 32'h50, 32'h60, 1'b0, 1'b1);
      @(negedge clk);
      chk("t5_g0", 64'(req_ready), 64'h4);
      cyc;
      @(negedge clk);
      chk("t5_g1", 64'(req_ready), 64'h1);
      cyc;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5_hold_ready", 64'(req_ready), 64'd0);
         chk("t5_valid", 64'(rsp_valid), 64'd1);
         if (k == 0) held = {28'b0, rsp_id, rsp_last, rsp_cout, rsp_sum};
         else chk("t5_stable", {28'b0, rsp_id, rsp_last, rsp_cout, rsp_sum}, held);
         cyc;
      end
      chk("t5_count", 64'(acc_cnt), 64'd2);
      rsp_ready = 1'b1;
      req_valid[0] = 1'b0;
      req_valid[2] = 1'b0;
      @(negedge clk);
      chk("t5_release", 64'(req_ready), 64'h2);
      cyc;
      req_valid = '0;
      repeat (3) cyc;
      // reset in the middle of a chain on req 1
      set_req(1, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t6_b0", 64'(req_ready), 64'h2);
      cyc;
      set_req(1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      set_req(0, 1'b1, 32'h1, 32'h2, 1'b1, 1'b1);
      set_req(3, 1'b1, 32'h9, 32'h9, 1'b0, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_ready", 64'(req_ready), 64'd0);
      cyc;
      rst = 1'b0;
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t6_grant", 64'(req_ready), 64'h1);
      cyc;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t6_next", 64'(req_ready), 64'h8);
      cyc;
      req_valid = '0;
      for (int t = 0; t < 50 && q.size() != 0; t++) cyc;
      @(negedge clk);
      chk("drain_empty", 64'(q.size()), 64'd0);
      chk("final_busy", 64'(busy), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bk_add_arbiter.md
Name: bk_add_arbiter

Overview:
- Shares one combinational 2**N-bit Brent-Kung adder between NREQ requesters through valid/ready handshakes, with round-robin arbitration.
- Two-stage pipeline. The operand register drives the adder, and the result register captures sum and carry.
- Supports multi-word (chained) additions. A requester holds the grant across beats, and each beat's carry-out feeds the next beat's carry-in.
- Sits between the adder datapath and its client blocks.

Parameters:
N, 5, log2 of adder width; W = 2**N.
NREQ, 4, number of requesters; power of two, >= 2; IW = log2(NREQ).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous active-high reset.
req_valid  input  NREQ  per-requester request valid.
req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
req_last  input  NREQ  1 = final beat of a transaction; 0 = more beats follow.
req_cin  input  NREQ  carry-in, used only on a transaction's first beat.
req_a  input  NREQ*W  operand A; requester i at [i*W +: W].
req_b  input  NREQ*W  operand B, same packing.
rsp_valid  output  1  result valid.
rsp_ready  input  1  result consumer ready.
rsp_id  output  IW  index of the requester owning the result.
rsp_sum  output  W  sum.
rsp_cout  output  1  carry-out of this beat.
rsp_last  output  1  req_last of this beat.
add_a  output  W  to shared adder, driven from operand register.
add_b  output  W  to shared adder.
add_cin  output  1  to shared adder.
add_sum  input  W  from shared adder (combinational).
add_cout  input  1  from shared adder.
busy  output  1  high while either stage is valid or a chain lock is held.

Behaviour:
- Reset:
  - Clears s1_v, s2_v, lock, carry_reg, and rr_ptr (pointer = 0).
  - Outputs go to 0: req_ready, rsp_*, add_*, busy.
  - Reset mid-chain abandons the transaction; no response for in-flight beats.
- Stage 1 (s1) is the operand register. It holds A, B, cin, id, and last, and drives add_*.
- Stage 2 (s2) is the result register. It captures add_sum, add_cout, id, and last when s1 advances.
- Advance rules:
  - s2_adv = !s2_v | rsp_ready.
  - s1_adv = s1_v & s2_adv.
  - Grant allowed when !s1_v | s1_adv.
- Accept: req_ready[i] = grant allowed & (i is the winner), combinationally from req_valid. A beat is accepted on req_valid[i] & req_ready[i].
- Winner selection:
  - If lock is set, the only candidate is lock_id.
  - Otherwise, the first valid index searching from rr_ptr upward, modulo NREQ.
- Pointer update: rr_ptr <= winner+1 (mod NREQ) only on an accepted beat with req_last = 1.
- Lock:
  - Set on an accepted beat with req_last = 0; lock_id = winner.
  - Cleared on an accepted beat with req_last = 1.
  - While locked, other requesters are starved even if lock_id drops req_valid.
- Carry select for the s1 load:
  - Unlocked (first beat): req_cin.
  - Locked, and s1 currently holds the previous beat of the same transaction and is advancing: add_cout.
  - Otherwise: carry_reg.
- carry_reg <= add_cout whenever s1 advances a beat with last = 0.
- Latency: accept at edge t, rsp_valid from edge t+1 (after the s2 capture). That is two cycles from the request cycle, with no backpressure.
- Throughput: 1 beat per cycle, including chained beats.
- Backpressure: while rsp_valid & !rsp_ready, s2 holds. s1 holds if valid, and no grant occurs if s1 is full. Response fields are stable until handshake.
- Simultaneous events: a response handshake and a new accept in the same cycle are both legal; the pipeline shifts.
- Arithmetic:
  - The sum is modulo 2**W.
  - rsp_cout is bit W of A+B+cin for that beat.
  - For a chained transaction, the words concatenate LSW-first into a (beats*W)-bit sum.
- busy = s1_v | s2_v | lock.

Test Plan:
1. Single beat:
   - Stimulus: req 1 with A=32'hFFFF_FFFF, B=0, cin=1, last=1, rsp_ready=1.
   - Required: rsp_valid 2 cycles after the request cycle, sum=0, cout=1, id=1, last=1.
2. Round robin:
   - Stimulus: all four requesters valid every cycle, last=1, from reset.
   - Required: grant order 0,1,2,3,0,…; one req_ready per cycle; responses returned in the same order.
3. Chained 96-bit add:
   - Stimulus: req 2 sends three beats, LSW-first, of A=96'h0_FFFFFFFF_FFFFFFFF and B=1, cin=0. Req 0 is valid throughout.
   - Required: sums 0, 0, 1 with couts 1, 1, 0; req 0 is not granted until after req 2's last beat.
4. Chain gap:
   - Stimulus: req 3 chain with a 3-cycle req_valid drop between beat 1 (cout=1) and beat 2.
   - Required: beat 2 uses cin=1 from carry_reg; other requesters stay ungranted during the gap.
5. Backpressure:
   - Stimulus: hold rsp_ready=0 for 4 cycles with 3 requests pending.
   - Required: rsp fields stable; exactly two beats held (s1, s2); no further req_ready; all results in order after release.
6. Reset mid-chain:
   - Stimulus: assert rst after beat 1 of a 3-beat chain.
   - Required: next cycle has busy=0, rsp_valid=0, lock clear, rr_ptr=0; a new request from req 0 is granted with its own req_cin.
